stream_demux_rr: RTL

Sequential 1-to-N stream demultiplexer: the distributing counterpart of the combinational mux used throughout the combinational exercises. It accepts words from one valid/ready upstream port and steers each word to one of N_OUT downstream ports, either round-robin or by an explicit select. Each downstream port owns a one-word register slot, so every output is registered with a latency of 1 cycle. The block sits between a single producer and N parallel consumers, for example workers fed from one source.

---
 rtl/stream_demux_pkg.sv | 21 ++
 rtl/stream_demux_rr_slot.sv | 42 ++++
 rtl/stream_demux_rr.sv | 83 ++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared defaults and helpers for the round-robin stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    localparam int N_OUT_DEF = 4;
    localparam int WIDTH_DEF = 8;

    // Width of a port index; a single-bit select is the minimum so that the
    // select and pointer ports never collapse to zero width.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/stream_demux_rr_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-word register stage feeding a single downstream port.
//               A load in the same cycle as a drain replaces the word.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Occupancy and word storage; load wins over drain so a drained slot refills.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (load) begin
                r_valid <= 1'b1;
                r_data  <= load_data;
            end else if (r_valid && drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule : demux_slot
`default_nettype wire

// File: rtl/stream_demux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_rr
// Description : 1-to-N valid/ready stream demultiplexer. Words are steered
//               round-robin or by explicit select into per-port registered
//               slots (1 cycle latency). A blocked target stalls upstream.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_rr
    import stream_demux_pkg::*;
#(
    parameter  int N_OUT = N_OUT_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int SEL_W = sel_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rr_en,
    input  logic [SEL_W-1:0]       up_sel,
    input  logic                   up_valid,
    input  logic [WIDTH-1:0]       up_data,
    output logic                   up_ready,
    output logic [N_OUT-1:0]       down_valid,
    output logic [N_OUT*WIDTH-1:0] down_data,
    input  logic [N_OUT-1:0]       down_ready,
    output logic [SEL_W-1:0]       rr_ptr
);

    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] w_target;
    logic [N_OUT-1:0] w_sel_oh;
    logic [N_OUT-1:0] w_free;
    logic [N_OUT-1:0] w_load;
    logic             w_up_ready;
    logic             w_accept;

    // Decode the target index to one-hot; an out-of-range index yields all zeros.
    always_comb begin
        w_target = rr_en ? r_rr_ptr : up_sel;
        w_sel_oh = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_sel_oh[i] = (w_target == SEL_W'(i));
        end
    end

    // A slot is free when empty or being drained this cycle.
    assign w_free     = ~down_valid | down_ready;
    assign w_up_ready = ~rst & (|(w_sel_oh & w_free));
    assign w_accept   = up_valid & w_up_ready;
    assign w_load     = w_sel_oh & {N_OUT{w_accept}};
    assign up_ready   = w_up_ready;

    // Round-robin pointer advances only on an accepted word in round-robin mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept && rr_en) begin
            if (r_rr_ptr == SEL_W'(N_OUT - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= r_rr_ptr + SEL_W'(1);
            end
        end
    end

    assign rr_ptr = r_rr_ptr;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (w_load[gi]),
            .load_data (up_data),
            .drain     (down_ready[gi]),
            .valid     (down_valid[gi]),
            .data      (down_data[gi*WIDTH +: WIDTH])
        );
    end

endmodule : stream_demux_rr
`default_nettype wire
